nash_decipher: RTL

- Receive-side counterpart of the Nash cipher encipher path: consumes a serial ciphertext bitstream and recovers plaintext bytes.
- Walks the same red/blue permutation state graph as the encipher side. Each ciphertext bit selects red (0) or blue (1), so the decipher stays in lockstep with the sender.
- Table contents are fetched through a combinational lookup port wired to nash_permutation_tables. Output is byte-assembled with a valid/ready handshake.

---
 rtl/nash_decipher.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/nash_decipher.sv
// nash_decipher: serial Nash-cipher receiver that walks the red/blue permutation graph and assembles plaintext bytes.
// Define NASH_DECIPHER_BITCOUNT_EN to enable the 32-bit decoded-bit counter on bit_count.
module nash_decipher #(
   parameter int unsigned STATE_W = 8,
   parameter int unsigned BYTE_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_load,
   input  logic [STATE_W-1:0] key_state,
   input  logic               key_bit,
   input  logic               ct_bit,
   input  logic               ct_valid,
   output logic               ct_ready,
   output logic [STATE_W-1:0] table_index,
   input  logic [STATE_W-1:0] red_next_state,
   input  logic               red_transform,
   input  logic [STATE_W-1:0] blue_next_state,
   input  logic               blue_transform,
   output logic [BYTE_W-1:0]  pt_byte,
   output logic               pt_valid,
   input  logic               pt_ready,
   output logic               keyed,
   output logic [31:0]        bit_count
);

   localparam int unsigned      CNT_W    = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
   localparam int unsigned      SH_W     = BYTE_W - 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTE_W - 1);

   typedef enum logic [1:0] {
      ST_UNKEYED = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_STALL   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [STATE_W-1:0] idx_q, idx_d;
   logic               s_q, s_d;
   logic [SH_W-1:0]    shift_q, shift_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0]  pt_byte_q, pt_byte_d;
   logic               pt_valid_q, pt_valid_d;
   logic               accept_c;
   logic               p_c;
   logic               last_c;

   assign accept_c    = ct_valid & ct_ready;
   assign p_c         = ct_bit ^ s_q;
   assign last_c      = (bit_cnt_q == LAST_CNT);
   assign table_index = idx_q;
   assign pt_byte     = pt_byte_q;
   assign pt_valid    = pt_valid_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_UNKEYED;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: stall whenever the next cycle would hold a full shift behind an unconsumed byte
   always_comb begin
      state_d = state_q;
      if (key_load) begin
         state_d = ST_ACTIVE;
      end else if (state_q != ST_UNKEYED) begin
         state_d = (bit_cnt_d == LAST_CNT && pt_valid_d) ? ST_STALL : ST_ACTIVE;
      end
   end

   // FSM outputs
   always_comb begin
      ct_ready = 1'b0;
      keyed    = 1'b0;
      case (state_q)
         ST_ACTIVE: begin
            ct_ready = ~key_load;
            keyed    = 1'b1;
         end
         ST_STALL: begin
            keyed    = 1'b1;
         end
         default: begin
            ct_ready = 1'b0;
            keyed    = 1'b0;
         end
      endcase
   end

   // Datapath next-state: graph walk, keystream and byte assembly
   always_comb begin
      idx_d      = idx_q;
      s_d        = s_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      pt_byte_d  = pt_byte_q;
      pt_valid_d = pt_valid_q;
      if (key_load) begin
         idx_d      = key_state;
         s_d        = key_bit;
         shift_d    = '0;
         bit_cnt_d  = '0;
         pt_valid_d = 1'b0;
      end else begin
         if (pt_valid_q && pt_ready) begin
            pt_valid_d = 1'b0;
         end
         if (accept_c) begin
            if (ct_bit) begin
               idx_d = blue_next_state;
               s_d   = s_q ^ blue_transform;
            end else begin
               idx_d = red_next_state;
               s_d   = s_q ^ red_transform;
            end
            if (last_c) begin
               pt_byte_d  = {shift_q, p_c};
               pt_valid_d = 1'b1;
               shift_d    = '0;
               bit_cnt_d  = '0;
            end else begin
               shift_d   = SH_W'({shift_q, p_c});
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         s_q        <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         pt_byte_q  <= '0;
         pt_valid_q <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         s_q        <= s_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         pt_byte_q  <= pt_byte_d;
         pt_valid_q <= pt_valid_d;
      end
   end

`ifdef NASH_DECIPHER_BITCOUNT_EN
   logic [31:0] bit_count_q, bit_count_d;

   // Free-running accepted-bit counter, wraps at 2^32
   always_comb begin
      bit_count_d = bit_count_q;
      if (key_load) begin
         bit_count_d = '0;
      end else if (accept_c) begin
         bit_count_d = bit_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_count_q <= '0;
      end else begin
         bit_count_q <= bit_count_d;
      end
   end

   assign bit_count = bit_count_q;
`else
   assign bit_count = '0;
`endif

endmodule
